// File: rtl/regfile_2r1w_clr.sv
// rtl/regfile_2r1w_clr.sv - parametrised 2-read/1-write register file with bypass and sequential clear
module regfile_2r1w_clr #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int ZERO_REG0 = 0,
  parameter int BYPASS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_hits_zero;
  logic              bypass_ok;

  assign wr_hits_zero = (ZERO_REG0 != 0) && (wr_addr == '0);
  // Bypass only applies to a write that will actually land this edge.
  assign bypass_ok    = (BYPASS != 0) && (state_q == ST_IDLE) && wr_en;

  // Next-state and single memory write port: user write in IDLE, zero-fill in CLEAR.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    wr_drop_d = wr_en && (state_q == ST_CLEAR);
    case (state_q)
      ST_IDLE: begin
        mem_we = wr_en && !wr_hits_zero;
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered state, counter, drop flag and storage; reset wipes everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
      if (mem_we) begin
        mem_q[mem_waddr] <= mem_wdata;
      end
    end
  end

  // Read port A: stored value, overridden by bypass, then by the hardwired zero.
  always_comb begin
    rd_data_a = mem_q[rd_addr_a];
    if (bypass_ok && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end
    if ((ZERO_REG0 != 0) && (rd_addr_a == '0)) begin
      rd_data_a = '0;
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    rd_data_b = mem_q[rd_addr_b];
    if (bypass_ok && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end
    if ((ZERO_REG0 != 0) && (rd_addr_b == '0)) begin
      rd_data_b = '0;
    end
  end

  assign busy    = (state_q == ST_CLEAR);
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// tb/tb_regfile_2r1w_clr.sv - randomized self-checking bench for regfile_2r1w_clr
module tb_regfile_2r1w_clr;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic        clr_req;

  logic [31:0] rd_a0, rd_b0, rd_a1, rd_b1;
  logic        busy0, busy1, drop0, drop1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // dut0: default config (bypass on, no zero register)
  regfile_2r1w_clr #(.DATA_W(32), .ADDR_W(4), .ZERO_REG0(0), .BYPASS(1)) dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_a0), .rd_addr_b(rd_addr_b), .rd_data_b(rd_b0),
    .clr_req(clr_req), .busy(busy0), .wr_drop(drop0)
  );

  // dut1: hardwired zero register, no bypass
  regfile_2r1w_clr #(.DATA_W(32), .ADDR_W(4), .ZERO_REG0(1), .BYPASS(0)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_a1), .rd_addr_b(rd_addr_b), .rd_data_b(rd_b1),
    .clr_req(clr_req), .busy(busy1), .wr_drop(drop1)
  );

  // Reference model: contents per config, plus how many clear cycles remain.
  logic [31:0] m0 [16];
  logic [31:0] m1 [16];
  int          clr_left = 0;
  logic        drop_exp = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        m0[i] = '0;
        m1[i] = '0;
      end
      clr_left = 0;
      drop_exp = 1'b0;
    end else if (clr_left > 0) begin
      drop_exp = wr_en;
      m0[16 - clr_left] = '0;
      m1[16 - clr_left] = '0;
      clr_left = clr_left - 1;
    end else begin
      drop_exp = 1'b0;
      if (wr_en) begin
        m0[wr_addr] = wr_data;
        if (wr_addr != 4'd0) m1[wr_addr] = wr_data;
      end
      if (clr_req) clr_left = 16;
    end
  end

  function automatic logic [31:0] exp_rd(input int cfg, input logic [3:0] addr);
    if (cfg == 1 && addr == 4'd0) return 32'h0;
    if (cfg == 0 && clr_left == 0 && wr_en && wr_addr == addr) return wr_data;
    return (cfg == 0) ? m0[addr] : m1[addr];
  endfunction

  function automatic logic [131:0] exp_all();
    logic eb;
    eb = (clr_left > 0);
    return {exp_rd(0, rd_addr_a), exp_rd(0, rd_addr_b), exp_rd(1, rd_addr_a), exp_rd(1, rd_addr_b),
            eb, eb, drop_exp, drop_exp};
  endfunction

  task automatic idle_inputs();
    wr_en   = 1'b0;
    clr_req = 1'b0;
    reset   = 1'b1;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    idle_inputs();
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic test_reset();
    logic [131:0] obs;
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    #1;
    n_total++;
    if ({busy0, busy1, drop0, drop1} !== 4'b0) $display("FAIL reset_init_flags: got %b expected 0000", {busy0, busy1, drop0, drop1});
    else n_pass++;
    for (int i = 1; i < 16; i++) write_reg(4'(i), 32'hA5A50000 + i);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idle_inputs();
      rd_addr_a = 4'(i);
      rd_addr_b = 4'(15 - i);
      #1;
      obs = {rd_a0, rd_b0, rd_a1, rd_b1, busy0, busy1, drop0, drop1};
      n_total++;
      if (obs !== 132'h0) $display("FAIL reset_clears[%0d]: got %h expected 0", i, obs);
      else n_pass++;
    end
  endtask

  task automatic test_write_read();
    write_reg(4'd5, 32'hDEADBEEF);
    @(negedge clk);
    idle_inputs();
    rd_addr_a = 4'd5; rd_addr_b = 4'd5;
    #1;
    n_total++;
    if ({rd_a0, rd_b0, rd_a1, rd_b1} !== {4{32'hDEADBEEF}})
      $display("FAIL dual_read_same: got %h %h %h %h expected deadbeef", rd_a0, rd_b0, rd_a1, rd_b1);
    else n_pass++;
    rd_addr_b = 4'd6;
    #1;
    n_total++;
    if ({rd_b0, rd_b1} !== 64'h0) $display("FAIL read_b_other: got %h %h expected 0", rd_b0, rd_b1);
    else n_pass++;
  endtask

  task automatic test_bypass();
    logic [31:0] old1;
    @(negedge clk);
    idle_inputs();
    rd_addr_a = 4'd7;
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h12345678;
    old1 = m1[7];
    #1;
    n_total++;
    if (rd_a0 !== 32'h12345678) $display("FAIL bypass_on: got %h expected 12345678", rd_a0);
    else n_pass++;
    n_total++;
    if (rd_a1 !== old1) $display("FAIL bypass_off_pre: got %h expected %h", rd_a1, old1);
    else n_pass++;
    @(negedge clk);
    idle_inputs();
    #1;
    n_total++;
    if ({rd_a0, rd_a1} !== {2{32'h12345678}}) $display("FAIL bypass_post: got %h %h expected 12345678", rd_a0, rd_a1);
    else n_pass++;
  endtask

  task automatic test_zero_reg();
    write_reg(4'd0, 32'hFFFFFFFF);
    rd_addr_a = 4'd0;
    #1;
    n_total++;
    if (rd_a1 !== 32'h0) $display("FAIL zero_reg_during_write: got %h expected 0", rd_a1);
    else n_pass++;
    @(negedge clk);
    idle_inputs();
    #1;
    n_total++;
    if (rd_a1 !== 32'h0 || drop1 !== 1'b0) $display("FAIL zero_reg_read: got %h drop %b expected 0 drop 0", rd_a1, drop1);
    else n_pass++;
    n_total++;
    if (rd_a0 !== 32'hFFFFFFFF) $display("FAIL nonzero_reg0: got %h expected ffffffff", rd_a0);
    else n_pass++;
  endtask

  task automatic test_clear();
    int busy_cnt;
    for (int i = 0; i < 16; i++) write_reg(4'(i), 32'(i + 1));
    @(negedge clk);
    idle_inputs();
    clr_req = 1'b1;
    busy_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      idle_inputs();
      clr_req   = (c == 2);
      rd_addr_a = 4'($urandom_range(0, 15));
      rd_addr_b = 4'($urandom_range(0, 15));
      if (c == 4) begin
        wr_en = 1'b1; wr_addr = 4'd12; wr_data = 32'h55;
      end
      if (c == 9) begin
        rd_addr_a = 4'd7; rd_addr_b = 4'd8;
      end
      #1;
      if (busy0) busy_cnt++;
      n_total++;
      if ({rd_a0, rd_b0, rd_a1, rd_b1, busy0, busy1, drop0, drop1} !== exp_all())
        $display("FAIL clear_cycle[%0d]: got %h expected %h", c,
                 {rd_a0, rd_b0, rd_a1, rd_b1, busy0, busy1, drop0, drop1}, exp_all());
      else n_pass++;
      if (c == 9) begin
        n_total++;
        if (rd_a0 !== 32'h0 || rd_b0 !== 32'd9) $display("FAIL clear_half: got %h %h expected 0 9", rd_a0, rd_b0);
        else n_pass++;
      end
      if (c == 5 || c == 6) begin
        n_total++;
        if (drop0 !== (c == 5)) $display("FAIL wr_drop_pulse[%0d]: got %b expected %b", c, drop0, (c == 5));
        else n_pass++;
      end
    end
    n_total++;
    if (busy_cnt != 16) $display("FAIL busy_len: got %0d expected 16", busy_cnt);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idle_inputs();
      rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i);
      #1;
      n_total++;
      if ({rd_a0, rd_b0, rd_a1, rd_b1} !== 128'h0) $display("FAIL clear_done[%0d]: got %h %h expected 0", i, rd_a0, rd_b0);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i < 16; i++) write_reg(4'(i), 32'h100 + i);
    @(negedge clk);
    idle_inputs();
    clr_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      idle_inputs();
      if (c == 5) reset = 1'b0;
    end
    @(negedge clk);
    idle_inputs();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h99;
    rd_addr_a = 4'd10;
    #1;
    n_total++;
    if ({busy0, busy1, rd_a0, rd_a1} !== 66'h0) $display("FAIL reset_mid_clear: got busy %b data %h expected 0", busy0, rd_a0);
    else n_pass++;
    @(negedge clk);
    idle_inputs();
    rd_addr_a = 4'd3; rd_addr_b = 4'd15;
    #1;
    n_total++;
    if ({rd_a0, rd_a1, rd_b0, rd_b1} !== {32'h99, 32'h99, 64'h0}) $display("FAIL write_after_reset: got %h %h %h expected 99 99 0", rd_a0, rd_a1, rd_b0);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      idle_inputs();
      wr_en     = ($urandom_range(0, 2) != 0);
      wr_addr   = 4'($urandom_range(0, 15));
      wr_data   = $urandom;
      rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      clr_req   = ($urandom_range(0, 39) == 0);
      #1;
      n_total++;
      if ({rd_a0, rd_b0, rd_a1, rd_b1, busy0, busy1, drop0, drop1} !== exp_all())
        $display("FAIL random[%0d]: got %h expected %h", c,
                 {rd_a0, rd_b0, rd_a1, rd_b1, busy0, busy1, drop0, drop1}, exp_all());
      else n_pass++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w_clr.md
Name: regfile_2r1w_clr

Overview:
Parametrised register file with one write port and two independent read ports. Successor to the fixed 16x32 decoder/register/mux register file. Adds parametrised width and depth, an optional hardwired-zero register 0, and same-cycle write-to-read bypass. Also adds a sequential bulk-clear engine with a busy handshake, so the datapath can wipe the file without a global reset.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG0, 0, 1 = register 0 always reads 0 and writes to it are discarded.
- BYPASS, 1, 1 = a read of the address being written this cycle returns wr_data.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- wr_en  in  1  write enable, sampled on rising clk.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_data_a  out  DATA_W  read port A data (combinational).
- rd_addr_b  in  ADDR_W  read port B address.
- rd_data_b  out  DATA_W  read port B data (combinational).
- clr_req  in  1  request a sequential clear of all registers.
- busy  out  1  high while the clear engine runs.
- wr_drop  out  1  registered one-cycle flag: a write was discarded because busy was high.

Behaviour:
- Reset (reset==0 at a rising edge):
  - All DEPTH registers become 0; FSM goes to IDLE; clear counter becomes 0; busy=0; wr_drop=0.
  - Reset overrides writes, clr_req and an in-progress clear.
- Write: at a rising edge with reset==1, state IDLE and wr_en==1, reg[wr_addr] <= wr_data.
  - With ZERO_REG0=1, a write to address 0 is silently discarded; wr_drop is not raised.
- Reads: purely combinational, rd_data_x = reg[rd_addr_x]. Both ports may address the same register.
  - ZERO_REG0=1 and rd_addr_x==0: output is 0.
  - BYPASS=1, state IDLE, wr_en==1, wr_addr==rd_addr_x, and not the zero-register case: output is wr_data.
  - BYPASS=0: a read returns the pre-edge value; the new value is visible the cycle after the write edge.
- FSM states: IDLE, CLEAR. The state is registered; busy = (state==CLEAR).
  - IDLE: clr_req==1 at an edge -> CLEAR, counter <= 0. A write presented in that same cycle is still performed; the clear later overwrites it.
  - CLEAR: each edge sets reg[counter] <= 0 and increments counter. At the edge where counter==DEPTH-1 -> IDLE, counter <= 0.
  - busy is high for exactly DEPTH cycles, starting the cycle after clr_req is sampled.
  - clr_req while in CLEAR is ignored; it is not queued.
- During CLEAR:
  - wr_en writes are discarded and bypass is disabled.
  - Reads return the stored contents: already-cleared entries read 0, the rest keep their old values.
- wr_drop <= wr_en & (state==CLEAR) every edge; reset forces it to 0.
- Counter width is ADDR_W. Wrap from DEPTH-1 to 0 coincides with the return to IDLE.

Test Plan:
1. Reset clears contents:
   - Stimulus: write regs 1..15 with 0xA5A50000+i, then hold reset=0 for one edge.
   - Response: every read on both ports returns 0; busy=0; wr_drop=0.
2. Basic write and dual read:
   - Stimulus: write reg5=0xDEADBEEF; next cycle set rd_addr_a=5, rd_addr_b=5.
   - Response: both ports return 0xDEADBEEF. With rd_addr_b=6 instead, port B returns 0.
3. Bypass:
   - Stimulus: rd_addr_a=7, wr_en=1, wr_addr=7, wr_data=0x12345678; sample before the edge.
   - Response: with BYPASS=1, rd_data_a=0x12345678. With BYPASS=0, rd_data_a holds the old value until after the edge.
4. Zero register:
   - Stimulus: ZERO_REG0=1, write reg0=0xFFFFFFFF.
   - Response: rd_data_a at address 0 reads 0; wr_drop stays 0. With ZERO_REG0=0 the same read returns 0xFFFFFFFF.
5. Sequential clear:
   - Stimulus: fill reg i with i+1 (DEPTH=16), pulse clr_req for one cycle.
   - Response: busy is high exactly 16 cycles.
   - After 8 busy edges, regs 0..7 read 0 and regs 8..15 read 9..16.
   - A write reg12=0x55 during busy is discarded; wr_drop pulses for one cycle.
   - After busy falls, all registers read 0.
6. Reset mid-clear:
   - Stimulus: assert reset=0 for one edge on the 5th busy cycle.
   - Response: busy=0 after that edge; all registers read 0.
   - A write reg3=0x99 on the next cycle succeeds and reads back 0x99.
